// File: rtl/mux41_rr_arb.sv
// Round-robin arbiter sharing a 4:1 mux into a valid/ready output register.
// Define ARB_BURST_EN to let the last winner hold the grant for up to P_BURST words.
module mux41_rr_arb #(
  parameter int P_WIDTH = 8,
  parameter int P_BURST = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [3:0]         i_req,
  input  logic [P_WIDTH-1:0] i_d_0,
  input  logic [P_WIDTH-1:0] i_d_1,
  input  logic [P_WIDTH-1:0] i_d_2,
  input  logic [P_WIDTH-1:0] i_d_3,
  output logic [3:0]         o_ack,
  output logic [P_WIDTH-1:0] o_y,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [1:0]         o_sel
);

  typedef enum logic {EMPTY, FULL} state_t;

  if (P_BURST < 1 || P_BURST > 15) begin : g_bad_burst
    $error("P_BURST out of range 1..15");
  end

  state_t               state_q, state_d;
  logic [P_WIDTH-1:0]   y_q, y_d;
  logic [1:0]           sel_q, sel_d;
  logic [1:0]           last_q, last_d;
  logic                 cap_en;
  logic                 cap;
  logic [1:0]           rr_win;
  logic [1:0]           win;
  logic                 found;
  logic [1:0]           cand;
  logic [P_WIDTH-1:0]   win_d;

  assign cap_en = (state_q == EMPTY) | i_ready;
  assign cap    = cap_en & (|i_req);

  // First set request after the previous winner, wrapping back to it last
  always_comb begin
    rr_win = last_q;
    found  = 1'b0;
    cand   = last_q;
    for (int i = 1; i <= 4; i++) begin
      cand = last_q + 2'(i);
      if (!found && i_req[cand]) begin
        rr_win = cand;
        found  = 1'b1;
      end
    end
  end

`ifdef ARB_BURST_EN
  logic [3:0] cnt_q, cnt_d;
  logic       hold;

  // cnt_q == 0 only after reset, so no burst is inherited from the reset pointer
  assign hold = i_req[last_q] && (cnt_q != 4'd0) && (cnt_q < 4'(P_BURST));
  assign win  = hold ? last_q : rr_win;

  always_comb begin
    cnt_d = cnt_q;
    if (cap) cnt_d = hold ? cnt_q + 4'd1 : 4'd1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) cnt_q <= 4'd0;
    else       cnt_q <= cnt_d;
  end
`else
  assign win = rr_win;
`endif

  always_comb begin
    case (win)
      2'd0:    win_d = i_d_0;
      2'd1:    win_d = i_d_1;
      2'd2:    win_d = i_d_2;
      default: win_d = i_d_3;
    endcase
  end

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    sel_d   = sel_q;
    last_d  = last_q;
    o_ack   = 4'b0000;
    if (cap) begin
      state_d = FULL;
      y_d     = win_d;
      sel_d   = win;
      last_d  = win;
      if (!i_rst) o_ack = 4'b0001 << win;
    end else if (state_q == FULL && i_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= EMPTY;
      y_q     <= '0;
      sel_q   <= 2'd0;
      last_q  <= 2'd3;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
    end
  end

  assign o_y     = y_q;
  assign o_sel   = sel_q;
  assign o_valid = (state_q == FULL);

endmodule
